// File: rtl/timer_bank_pkg.sv
// Shared constants and types for the parametrised timer bank.
package timer_bank_pkg;

  localparam int TMR_ACTIVE_BIT  = 28;
  localparam int TMR_MODE_BIT    = 29;
  localparam int TMR_IEN_BIT     = 30;

  localparam int MAX_TIMERS      = 32;
  localparam int MAX_TIMER_WIDTH = 28;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_RELOAD  = 1'b1
  } tmr_mode_e;

endpackage

// File: rtl/timer_bank_param_channel.sv
// One down-counting timer: count, hidden reload value, control bits and a
// combinational expiry pulse that the bank latches into its status register.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int TIMER_WIDTH = 20
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  output logic [31:0] word_o,
  output logic        expire_o
);

  localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

  logic [TIMER_WIDTH-1:0] count_q, count_d;
  logic [TIMER_WIDTH-1:0] reload_q, reload_d;
  logic                   active_q, active_d;
  tmr_mode_e              mode_q, mode_d;
  logic                   ien_q, ien_d;
  logic                   unused_data;

  // Only the count field and the three control bits are stored.
  assign unused_data = ^load_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      reload_q <= '0;
      active_q <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      ien_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      active_q <= active_d;
      mode_q   <= mode_d;
      ien_q    <= ien_d;
    end
  end

  // A load overrides a coincident tick, so it can never report an expiry.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    active_d = active_q;
    mode_d   = mode_q;
    ien_d    = ien_q;
    expire_o = 1'b0;
    if (load_i) begin
      count_d  = load_data_i[TIMER_WIDTH-1:0];
      reload_d = load_data_i[TIMER_WIDTH-1:0];
      active_d = load_data_i[TMR_ACTIVE_BIT];
      mode_d   = tmr_mode_e'(load_data_i[TMR_MODE_BIT]);
      ien_d    = load_data_i[TMR_IEN_BIT];
    end else if (tick_i && active_q) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else if (count_q == ONE) begin
        expire_o = 1'b1;
        if (mode_q == MODE_RELOAD) begin
          count_d = reload_q;
        end else begin
          count_d  = '0;
          active_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    word_o                    = '0;
    word_o[TIMER_WIDTH-1:0]   = count_q;
    word_o[TMR_ACTIVE_BIT]    = active_q;
    word_o[TMR_MODE_BIT]      = mode_q;
    word_o[TMR_IEN_BIT]       = ien_q;
  end

endmodule

// File: rtl/timer_bank_param.sv
// Parametrised bank of down-counting timers on an AVMM slave with sticky
// W1C expiry status and a registered level interrupt.
module timer_bank_param
  import timer_bank_pkg::*;
#(
  parameter int NUM_TIMERS  = 8,
  parameter int TIMER_WIDTH = 20,
  parameter int ADDR_WIDTH  = $clog2(NUM_TIMERS + 1)
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  iTickCE,
  input  logic [ADDR_WIDTH-1:0] avmm_address,
  input  logic                  avmm_read,
  input  logic                  avmm_write,
  input  logic [31:0]           avmm_writedata,
  output logic [31:0]           avmm_readdata,
  output logic                  avmm_readdatavalid,
  output logic                  irq
);

  if (NUM_TIMERS < 1 || NUM_TIMERS > MAX_TIMERS) begin : g_bad_num_timers
    $error("timer_bank_param: NUM_TIMERS out of range 1..32");
  end
  if (TIMER_WIDTH < 1 || TIMER_WIDTH > MAX_TIMER_WIDTH) begin : g_bad_timer_width
    $error("timer_bank_param: TIMER_WIDTH out of range 1..28");
  end

  logic [1:0]            rst_sync_q;
  logic                  rst_n;
  logic [1:0]            tick_hist_q;
  logic                  tick;
  logic [NUM_TIMERS-1:0] load_vec;
  logic [NUM_TIMERS-1:0] expire_vec;
  logic [NUM_TIMERS-1:0] ien_vec;
  logic [NUM_TIMERS-1:0] w1c_mask;
  logic [NUM_TIMERS-1:0] expired_q, expired_d;
  logic [31:0]           words [NUM_TIMERS];
  logic                  status_wr;
  logic [31:0]           rd_word;
  logic [31:0]           rdata_q;
  logic                  rvalid_q;
  logic                  irq_q;

  // Assertion is immediate; release is retimed so no flop leaves reset mid-cycle.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_hist_q <= 2'b00;
    else        tick_hist_q <= {tick_hist_q[0], iTickCE};
  end
  assign tick = tick_hist_q[0] & ~tick_hist_q[1];

  assign status_wr = avmm_write && (avmm_address == ADDR_WIDTH'(NUM_TIMERS));
  assign w1c_mask  = status_wr ? avmm_writedata[NUM_TIMERS-1:0] : '0;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
    assign load_vec[i] = avmm_write && (avmm_address == ADDR_WIDTH'(i));
    assign ien_vec[i]  = words[i][TMR_IEN_BIT];

    timer_channel #(
      .TIMER_WIDTH(TIMER_WIDTH)
    ) u_channel (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .tick_i      (tick),
      .load_i      (load_vec[i]),
      .load_data_i (avmm_writedata),
      .word_o      (words[i]),
      .expire_o    (expire_vec[i])
    );
  end

  // A new expiry beats a clear arriving in the same cycle.
  assign expired_d = (expired_q & ~load_vec & ~w1c_mask) | expire_vec;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (avmm_address == ADDR_WIDTH'(k)) rd_word = words[k];
    end
    if (avmm_address == ADDR_WIDTH'(NUM_TIMERS)) rd_word[NUM_TIMERS-1:0] = expired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expired_q <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      expired_q <= expired_d;
      irq_q     <= |(expired_q & ien_vec);
      rvalid_q  <= avmm_read;
      if (avmm_read) rdata_q <= rd_word;
    end
  end

  assign avmm_readdata      = rdata_q;
  assign avmm_readdatavalid = rvalid_q;
  assign irq                = irq_q;

endmodule

// File: tb/tb_timer_bank_param.sv
// Directed self-checking bench for timer_bank_param: default build plus the
// NUM_TIMERS=1/TIMER_WIDTH=28 and NUM_TIMERS=32/TIMER_WIDTH=1 corners.
module tb_timer_bank_param;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        iTickCE = 1'b0;

  logic [3:0]  addr = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] wd = '0, rdata;
  logic        rv, irq;

  logic [0:0]  a1 = '0;
  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] wd1 = '0, rdata1;
  logic        rv1, irq1;

  logic [5:0]  a32 = '0;
  logic        rd32 = 1'b0, wr32 = 1'b0;
  logic [31:0] wd32 = '0, rdata32;
  logic        rv32, irq32;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  timer_bank_param dut (
    .clk(clk), .areset_n(areset_n), .iTickCE(iTickCE),
    .avmm_address(addr), .avmm_read(rd), .avmm_write(wr), .avmm_writedata(wd),
    .avmm_readdata(rdata), .avmm_readdatavalid(rv), .irq(irq)
  );

  timer_bank_param #(.NUM_TIMERS(1), .TIMER_WIDTH(28)) dut1 (
    .clk(clk), .areset_n(areset_n), .iTickCE(iTickCE),
    .avmm_address(a1), .avmm_read(rd1), .avmm_write(wr1), .avmm_writedata(wd1),
    .avmm_readdata(rdata1), .avmm_readdatavalid(rv1), .irq(irq1)
  );

  timer_bank_param #(.NUM_TIMERS(32), .TIMER_WIDTH(1)) dut32 (
    .clk(clk), .areset_n(areset_n), .iTickCE(iTickCE),
    .avmm_address(a32), .avmm_read(rd32), .avmm_write(wr32), .avmm_writedata(wd32),
    .avmm_readdata(rdata32), .avmm_readdatavalid(rv32), .irq(irq32)
  );

  task automatic wr_m(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1 addr = a; wd = d; wr = 1'b1;
    @(posedge clk); #1 wr = 1'b0;
  endtask

  task automatic rd_m(input logic [3:0] a, output logic [31:0] d, output logic v);
    @(posedge clk); #1 addr = a; rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0; d = rdata; v = rv;
  endtask

  task automatic wr_1(input logic [0:0] a, input logic [31:0] d);
    @(posedge clk); #1 a1 = a; wd1 = d; wr1 = 1'b1;
    @(posedge clk); #1 wr1 = 1'b0;
  endtask

  task automatic rd_1(input logic [0:0] a, output logic [31:0] d);
    @(posedge clk); #1 a1 = a; rd1 = 1'b1;
    @(posedge clk); #1 rd1 = 1'b0; d = rdata1;
  endtask

  task automatic wr_32(input logic [5:0] a, input logic [31:0] d);
    @(posedge clk); #1 a32 = a; wd32 = d; wr32 = 1'b1;
    @(posedge clk); #1 wr32 = 1'b0;
  endtask

  task automatic rd_32(input logic [5:0] a, output logic [31:0] d);
    @(posedge clk); #1 a32 = a; rd32 = 1'b1;
    @(posedge clk); #1 rd32 = 1'b0; d = rdata32;
  endtask

  // One rising edge of iTickCE; returns just after the edge that consumes it.
  task automatic do_tick();
    @(posedge clk); #1 iTickCE = 1'b1;
    @(posedge clk); #1 iTickCE = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    total++; if (rv !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", rv); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    @(posedge clk); #2 areset_n = 1'b1;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      rd_m(4'(k), d, v);
      total++; if (d !== 32'h0 || v !== 1'b1) begin
        bad++; $display("FAIL reset_read addr=%0d got=%h/%b exp=00000000/1", k, d, v);
      end
    end
    @(posedge clk); #1;
    total++; if (rv !== 1'b0) begin bad++; $display("FAIL rvalid_pulse got=%b exp=0", rv); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq2 got=%b exp=0", irq); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic v;
    logic [31:0] exp_seq [3] = '{32'h1000_0002, 32'h1000_0001, 32'h0000_0000};
    wr_m(4'd2, 32'h1000_0003);
    rd_m(4'd2, d, v);
    total++; if (d !== 32'h1000_0003) begin bad++; $display("FAIL oneshot_load got=%h exp=%h", d, 32'h1000_0003); end
    for (int t = 0; t < 3; t++) begin
      do_tick();
      rd_m(4'd2, d, v);
      total++; if (d !== exp_seq[t]) begin bad++; $display("FAIL oneshot_tick%0d got=%h exp=%h", t + 1, d, exp_seq[t]); end
    end
    rd_m(4'd8, d, v);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL oneshot_status got=%h exp=%h", d, 32'h4); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq got=%b exp=0", irq); end
  endtask

  task automatic test_reload();
    logic [31:0] d;
    logic v;
    wr_m(4'd8, 32'h4);
    wr_m(4'd0, 32'h7000_0002);
    do_tick();
    rd_m(4'd0, d, v);
    total++; if (d !== 32'h7000_0001) begin bad++; $display("FAIL reload_t1 got=%h exp=%h", d, 32'h7000_0001); end
    rd_m(4'd8, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reload_status_t1 got=%h exp=0", d); end
    do_tick();
    rd_m(4'd0, d, v);
    total++; if (d !== 32'h7000_0002) begin bad++; $display("FAIL reload_t2 got=%h exp=%h", d, 32'h7000_0002); end
    rd_m(4'd8, d, v);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL reload_status_t2 got=%h exp=1", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL reload_irq_set got=%b exp=1", irq); end
    @(posedge clk); #1;
    total++; if (rv !== 1'b0 || rdata !== 32'h1) begin
      bad++; $display("FAIL rdata_hold got=%h/%b exp=00000001/0", rdata, rv);
    end
    wr_m(4'd8, 32'h1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_lag got=%b exp=1", irq); end
    @(posedge clk); #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_clr got=%b exp=0", irq); end
    do_tick();
    rd_m(4'd0, d, v);
    total++; if (d !== 32'h7000_0001) begin bad++; $display("FAIL reload_t3 got=%h exp=%h", d, 32'h7000_0001); end
    do_tick();
    rd_m(4'd0, d, v);
    total++; if (d !== 32'h7000_0002) begin bad++; $display("FAIL reload_t4 got=%h exp=%h", d, 32'h7000_0002); end
    rd_m(4'd8, d, v);
    total++; if (d !== 32'h1 || irq !== 1'b1) begin
      bad++; $display("FAIL reload_reexpire got=%h/%b exp=00000001/1", d, irq);
    end
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    logic v;
    wr_m(4'd0, 32'h0);
    wr_m(4'd3, 32'h1000_0001);
    @(posedge clk); #1 iTickCE = 1'b1;
    @(posedge clk); #1 iTickCE = 1'b0; addr = 4'd3; wd = 32'h1000_0005; wr = 1'b1;
    @(posedge clk); #1 wr = 1'b0;
    rd_m(4'd3, d, v);
    total++; if (d !== 32'h1000_0005) begin bad++; $display("FAIL write_vs_tick got=%h exp=%h", d, 32'h1000_0005); end
    rd_m(4'd8, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL write_vs_tick_status got=%h exp=0", d); end
    wr_m(4'd4, 32'h1000_0001);
    @(posedge clk); #1 iTickCE = 1'b1;
    @(posedge clk); #1 iTickCE = 1'b0; addr = 4'd8; wd = 32'h10; wr = 1'b1;
    @(posedge clk); #1 wr = 1'b0;
    rd_m(4'd8, d, v);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL w1c_vs_set got=%h exp=%h", d, 32'h10); end
    rd_m(4'd4, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_vs_set_timer got=%h exp=0", d); end
    rd_m(4'd3, d, v);
    total++; if (d !== 32'h1000_0004) begin bad++; $display("FAIL collide_t3 got=%h exp=%h", d, 32'h1000_0004); end
  endtask

  task automatic test_hold_and_unmapped();
    logic [31:0] d;
    logic v;
    @(posedge clk); #1 iTickCE = 1'b1;
    repeat (10) @(posedge clk);
    #1 iTickCE = 1'b0;
    repeat (2) @(posedge clk);
    rd_m(4'd3, d, v);
    total++; if (d !== 32'h1000_0003) begin bad++; $display("FAIL hold_high got=%h exp=%h", d, 32'h1000_0003); end
    wr_m(4'd9, 32'hFFFF_FFFF);
    rd_m(4'd9, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", d); end
    rd_m(4'd3, d, v);
    total++; if (d !== 32'h1000_0003) begin bad++; $display("FAIL unmapped_t3 got=%h exp=%h", d, 32'h1000_0003); end
    rd_m(4'd8, d, v);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL unmapped_status got=%h exp=%h", d, 32'h10); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    logic v;
    wr_m(4'd5, 32'h7000_0007);
    do_tick();
    rd_m(4'd5, d, v);
    total++; if (d !== 32'h7000_0006) begin bad++; $display("FAIL mid_before got=%h exp=%h", d, 32'h7000_0006); end
    @(posedge clk); #3 areset_n = 1'b0;
    #1;
    total++; if (rdata !== 32'h0 || rv !== 1'b0 || irq !== 1'b0) begin
      bad++; $display("FAIL mid_async got=%h/%b/%b exp=00000000/0/0", rdata, rv, irq);
    end
    repeat (2) @(posedge clk);
    #2 areset_n = 1'b1;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      rd_m(4'(k), d, v);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_read addr=%0d got=%h exp=0", k, d); end
    end
    do_tick();
    rd_m(4'd5, d, v);
    total++; if (d !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL mid_stopped got=%h/%b exp=00000000/0", d, irq);
    end
  endtask

  task automatic test_variants();
    logic [31:0] d;
    wr_1(1'b0, 32'h1FFF_FFFF);
    rd_1(1'b0, d);
    total++; if (d !== 32'h1FFF_FFFF) begin bad++; $display("FAIL w28_load got=%h exp=%h", d, 32'h1FFF_FFFF); end
    do_tick();
    rd_1(1'b0, d);
    total++; if (d !== 32'h1FFF_FFFE) begin bad++; $display("FAIL w28_dec got=%h exp=%h", d, 32'h1FFF_FFFE); end
    wr_1(1'b0, 32'h5000_0002);
    do_tick();
    rd_1(1'b0, d);
    total++; if (d !== 32'h5000_0001) begin bad++; $display("FAIL w28_t1 got=%h exp=%h", d, 32'h5000_0001); end
    do_tick();
    rd_1(1'b0, d);
    total++; if (d !== 32'h4000_0000) begin bad++; $display("FAIL w28_t2 got=%h exp=%h", d, 32'h4000_0000); end
    rd_1(1'b1, d);
    total++; if (d !== 32'h1 || irq1 !== 1'b1) begin
      bad++; $display("FAIL w28_status got=%h/%b exp=00000001/1", d, irq1);
    end
    wr_32(6'd31, 32'h5000_0001);
    wr_32(6'd0, 32'h3000_0001);
    do_tick();
    rd_32(6'd31, d);
    total++; if (d !== 32'h4000_0000) begin bad++; $display("FAIL n32_t31 got=%h exp=%h", d, 32'h4000_0000); end
    rd_32(6'd0, d);
    total++; if (d !== 32'h3000_0001) begin bad++; $display("FAIL n32_t0 got=%h exp=%h", d, 32'h3000_0001); end
    rd_32(6'd32, d);
    total++; if (d !== 32'h8000_0001 || irq32 !== 1'b1) begin
      bad++; $display("FAIL n32_status got=%h/%b exp=80000001/1", d, irq32);
    end
    wr_32(6'd32, 32'h8000_0000);
    @(posedge clk); #1;
    rd_32(6'd32, d);
    total++; if (d !== 32'h1 || irq32 !== 1'b0) begin
      bad++; $display("FAIL n32_w1c got=%h/%b exp=00000001/0", d, irq32);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_collisions();
    test_hold_and_unmapped();
    test_reset_midcount();
    test_variants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/timer_bank_param.md
# timer_bank_param

Parametrised bank of independent down-counting timers driven by a shared, clk-synchronous periodic tick enable (20 ms in current designs). It replaces the fixed three-timer bank. New features: configurable timer count and width, per-timer one-shot or auto-reload mode, sticky expiry status with write-1-to-clear, a level interrupt, and registered AVMM reads with a readdatavalid strobe. It sits on the management AVMM fabric and is used by the recovery/watchdog firmware.

## Interface
- NUM_TIMERS, 8: number of timers; legal range 1..32.
- TIMER_WIDTH, 20: counter width; legal range 1..28.
- ADDR_WIDTH, $clog2(NUM_TIMERS+1): derived; not overridden.
- clk  in  1  system clock
- areset_n  in  1  asynchronous, active-low reset
- iTickCE  in  1  periodic tick enable, synchronous to clk; it may stay high for multiple cycles
- avmm_address  in  ADDR_WIDTH  word address
- avmm_read  in  1  read request
- avmm_write  in  1  write request
- avmm_writedata  in  32  write data
- avmm_readdata  out  32  registered read data
- avmm_readdatavalid  out  1  high for exactly one cycle, one cycle after avmm_read
- irq  out  1  level interrupt, registered

## Operation
- **Timer word, address i < NUM_TIMERS**
  - Bits [TIMER_WIDTH-1:0]: count.
  - Bit 28: active.
  - Bit 29: reload mode (1 = auto-reload).
  - Bit 30: irq enable.
  - All other bits read 0.
- **Write to a timer word**
  - Loads the count and the hidden reload register from wdata[TIMER_WIDTH-1:0].
  - Loads active, mode and ien from wdata.
  - Clears expired[i].
- **Status, address NUM_TIMERS**
  - Bits [NUM_TIMERS-1:0] hold expired flags; writing 1 clears a bit (W1C).
  - Upper bits read 0.
- **Unmapped addresses**: writes are ignored; reads return 0.
- **Tick event**: a single-cycle internal pulse on the iTickCE 0→1 edge, from a two-flop history (prev=0, cur=1).
- **On a tick event, each timer with active=1:**
  - count > 1: decrement count.
  - count == 1, one-shot: count becomes 0, active clears, expired[i] sets.
  - count == 1, reload: count becomes the reload value, active stays 1, expired[i] sets.
  - count == 0: no change and no expiry (loading 0 while active is a no-op).
- **Inactive timers** hold their count.
- **irq** = registered OR over i of (expired[i] & ien[i]).
- **Simultaneous events**
  - A timer-word write and a tick in the same cycle: the write wins, and no expiry is recorded for that timer on that tick.
  - A W1C and a new expiry of the same bit in the same cycle: set wins.
  - Reads sample register state before that cycle's update.

## Timing
- Reset: all counts, reload values, active/mode/ien and expired bits are 0; tick history is 00; avmm_readdata = 0, avmm_readdatavalid = 0, irq = 0.
- Reset is asynchronous on assertion; internal state is released synchronously (the tick history restarts at 00).
- Read latency is 1 cycle. Back-to-back reads are allowed, one result per cycle. There is no waitrequest.
- When avmm_readdatavalid = 0, avmm_readdata holds its previous value.
- Writes take effect on the clk edge where avmm_write = 1. A read of the same word in the next cycle returns the new value.
- Expiry: expired[i] sets on the edge that consumes the tick event (first cycle after the 0→1 edge is sampled). irq follows one cycle later.
- Reset mid-count: the timer stops immediately and returns to 0; no expiry is reported.
- iTickCE held high produces only one tick event.

## Structure
- Package timer_bank_pkg holds:
  - Bit-position constants: TMR_ACTIVE_BIT = 28, TMR_MODE_BIT = 29, TMR_IEN_BIT = 30.
  - Mode enum: one-shot / reload.
  - Range-check helper constants: maximum timers 32, maximum width 28.
- Sub-module timer_channel, instantiated NUM_TIMERS times by generate:
  - Contains count, reload, control bits and the expiry pulse.
  - Inputs: tick, load, load data.
  - The top level owns tick detection, the expired/W1C register, the irq register and read muxing.
- Elaboration-time assertions check the parameter ranges.

## Test plan
- Reset, then read every address → all 0; readdatavalid pulses one cycle after each read; irq = 0.
- Write timer 2 = 0x1000_0003 (one-shot, active, count 3); issue 3 ticks → count reads 2, 1, 0; active = 0; status bit2 = 1; irq stays 0 (ien = 0).
- Write timer 0 = 0x7000_0002 (reload, ien, active); issue 4 ticks → count sequence 1, 2, 1, 2; expired[0] sets at tick 2; irq = 1; W1C 0x1 → irq = 0 two cycles later; re-expiry at tick 4.
- Write a timer in the same cycle as a tick edge with count = 1 → the written value is held, no expiry; W1C colliding with a new expiry → the bit stays 1.
- Hold iTickCE high for 10 cycles → exactly one decrement; write to address NUM_TIMERS+1 → no state change, and a read returns 0.
- Assert areset_n low mid-count for timer 5 (count 7) → all registers read 0 after release, no spurious irq; repeat the scenarios with NUM_TIMERS = 1/TIMER_WIDTH = 28 and NUM_TIMERS = 32/TIMER_WIDTH = 1.
